formic_bctl_trace_arb: RTL
==========================

# formic_bctl_trace_arb

Board-controller trace arbiter. It shares the single downstream trace byte stream among `NSRC` trace input buffers. Each buffer holds whole 8-byte trace records and exposes a head-of-queue byte, a valid flag, a dequeue strobe and a drop indication. The arbiter grants one source at a time, round-robin at record granularity, and moves exactly 8 bytes per grant. With the header feature compiled in, it also emits a source/drop header byte before each record.

## Interface
- `NSRC`, 4: number of trace sources; power of two, 2..8.
- `SW`, 2: source-id width, log2(`NSRC`).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_src_data` in `NSRC*8`: head byte per source; source k occupies bits [8k+7:8k].
- `i_src_valid` in `NSRC`: head byte of source k is valid.
- `i_src_drop` in `NSRC`: source k dropped a record (level or pulse).
- `o_src_deq` out `NSRC`: pop one byte from source k.
- `i_src_en` in `NSRC`: source enable mask; a masked source is never granted.
- `o_data` out 8: output byte.
- `o_valid` out 1: `o_data` is valid.
- `i_ready` in 1: downstream accepts the byte; a transfer occurs when `o_valid & i_ready`.
- `o_busy` out 1: a grant is active (state is not Idle).
- `o_gnt` out `SW`: id of the current or last granted source.

## Operation
- FSM states: Idle, Hdr, Data.
- **Idle**
  - req = `i_src_valid & i_src_en`.
  - If req is nonzero, grant the first requesting source at or after `rr_ptr` (wrapping modulo `NSRC`).
  - Latch the grant into `gnt`. Go to Hdr (header enabled) or Data (header disabled).
  - `o_valid`=0 and all `o_src_deq`=0 in Idle.
- **Hdr**
  - `o_valid`=1.
  - `o_data` = {`drop_flag[gnt]`, zeros, `gnt`}: bit 7 is the drop flag, bits [SW-1:0] are the source id.
  - On transfer: clear `drop_flag[gnt]` and go to Data.
- **Data**
  - `o_valid` = `i_src_valid[gnt]`; `o_data` = head byte of source `gnt`.
  - `o_src_deq[gnt]` = `i_src_valid[gnt] & i_ready`, combinational.
  - `byte_cnt` (3 bits) increments on each transfer.
  - On the transfer with `byte_cnt`==7: go to Idle, set `rr_ptr` = `gnt`+1 (wrapping), reset `byte_cnt` to 0.
- `drop_flag[k]`: sticky. It is set on any cycle where `i_src_drop[k]`=1.
- If a set and a clear of `drop_flag[k]` happen in the same cycle, the set wins. The new drop is reported in the next header.
- `i_src_valid[gnt]` deasserting mid-record stalls the grant. The record is never abandoned and no other source is granted until 8 bytes have transferred.
- Changes to `i_src_en` take effect only at the next Idle arbitration. An in-progress record always completes.
- The source id is encoded as an unsigned `SW`-bit value. `rr_ptr` wraps from `NSRC`-1 to 0.

## Timing
- Reset values:
  - State = Idle.
  - `rr_ptr`=0, `gnt`=0, `byte_cnt`=0, `drop_flag`=0.
  - `o_valid`=0, `o_src_deq`=0, `o_busy`=0, `o_gnt`=0, `o_data`=0.
- Reset mid-record returns everything to reset values on the next edge. Sources share `rst`, so a partial record is discarded on both sides.
- Arbitration costs one Idle cycle. The earliest header is on the cycle after req is seen.
- Back-to-back throughput with `i_ready`=1 and full sources: 10 cycles per record with the header (1 arb + 1 hdr + 8 data), 9 without.
- `o_data`, `o_valid` and `o_src_deq` are combinational from state, grant and source inputs. No registered output stage. Downstream must not combine `i_ready` with `o_valid`.
- `o_busy`/`o_gnt` are registered and change on the edge that leaves Idle.

## Configuration
- Macro `FORMIC_TRACE_ARB_HDR_EN`.
- **Defined:** Hdr state present; each record is preceded by a header byte. `drop_flag` is reported and cleared through the header.
- **Undefined:** Hdr state and `drop_flag` are removed; Idle goes directly to Data. The output is raw 8-byte records, and drop information is not forwarded (`i_src_drop` is unused).

## Structure
- Shared package `formic_bctl_pkg`:
  - Record length constant `TRACE_REC_BYTES` = 8.
  - Header bit position `TRACE_HDR_DROP_BIT` = 7.
  - One-hot state encodings.
- One sub-module: `formic_bctl_rr_pick`, a combinational round-robin priority picker (req vector plus `rr_ptr` in, grant id and any-flag out). Everything else stays in the top module.

## Test plan
- **Single record:** source 2 valid with bytes 0x10..0x17, `i_ready`=1, header enabled → 0x02, then 0x10..0x17. `o_src_deq[2]` pulses 8 times, then the FSM returns to Idle.
- **Round-robin:** sources 0, 1, 3 continuously valid → grant order 0, 1, 3, 0. Each record is 10 cycles apart; source 2 is never dequeued.
- **Backpressure and stall:** `i_ready` toggling 1/0 and `i_src_valid` dropping after byte 3 → exactly 8 data bytes in order, no deq while valid or ready is low, no grant switch.
- **Drop reporting:** `i_src_drop[1]` pulses before the grant → header 0x81. A second pulse in the header transfer cycle → the next source-1 header is 0x81 again. A record with no drop in between → 0x01.
- **Mask:** `i_src_en`=4'b1110 with all sources valid → source 0 is never granted. Clearing `en[1]` mid-record lets that record finish, and the next grant skips source 1.
- **Reset mid-record:** `rst` asserted after the 4th data byte → next cycle all outputs are 0, state is Idle, `rr_ptr`=0. The first post-reset grant goes to the lowest-index valid source.

Source files
------------

// File: rtl/formic_bctl_pkg.sv
// Shared constants for the board-controller trace path: record framing,
// header layout and the one-hot arbiter state encodings.
package formic_bctl_pkg;

   localparam int TRACE_REC_BYTES    = 8;
   localparam int TRACE_HDR_DROP_BIT = 7;

   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_HDR  = 3'b010;
   localparam logic [2:0] ST_DATA = 3'b100;

   typedef logic [7:0] trace_byte_t;

   // Header byte: source id in the low bits, drop flag in the top bit.
   function automatic trace_byte_t hdr_byte(input logic drop, input trace_byte_t id);
      trace_byte_t b;
      b = id;
      b[TRACE_HDR_DROP_BIT] = drop;
      return b;
   endfunction

endpackage

// File: rtl/formic_bctl_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after i_ptr,
// wrapping modulo NSRC (NSRC must be 2**SW).
module formic_bctl_rr_pick #(
   parameter int NSRC = 4,
   parameter int SW   = 2
) (
   input  logic [NSRC-1:0] i_req,
   input  logic [SW-1:0]   i_ptr,
   output logic [SW-1:0]   o_id,
   output logic            o_any
);

   logic [SW-1:0] idx;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      o_id  = '0;
      o_any = 1'b0;
      idx   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         idx = i_ptr + SW'(i);
         if (i_req[idx]) begin
            o_id  = idx;
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/formic_bctl_trace_arb.sv
// Trace arbiter: round-robin, record-granular sharing of one byte stream among
// NSRC trace buffers. Define FORMIC_TRACE_ARB_HDR_EN to prefix each record with a source/drop header.
module formic_bctl_trace_arb
   import formic_bctl_pkg::*;
#(
   parameter int NSRC = 4,
   parameter int SW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSRC*8-1:0] i_src_data,
   input  logic [NSRC-1:0]   i_src_valid,
   input  logic [NSRC-1:0]   i_src_drop,
   output logic [NSRC-1:0]   o_src_deq,
   input  logic [NSRC-1:0]   i_src_en,
   output logic [7:0]        o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic [SW-1:0]     o_gnt
);

   localparam logic [2:0] REC_LAST = 3'(TRACE_REC_BYTES - 1);

   logic [2:0]      state_q, state_d;
   logic [SW-1:0]   gnt_q, gnt_d;
   logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [2:0]      byte_cnt_q, byte_cnt_d;

   logic [NSRC-1:0] req;
   logic [SW-1:0]   pick_id;
   logic            pick_any;
   logic [7:0]      head_byte;
   logic            head_valid;
   logic            xfer;

`ifdef FORMIC_TRACE_ARB_HDR_EN
   logic [NSRC-1:0] drop_flag_q, drop_flag_d;
   logic [NSRC-1:0] drop_clr;
`else
   logic            unused_drop;
   assign unused_drop = ^i_src_drop;
`endif

   assign req = i_src_valid & i_src_en;

   formic_bctl_rr_pick #(
      .NSRC (NSRC),
      .SW   (SW)
   ) u_pick (
      .i_req (req),
      .i_ptr (rr_ptr_q),
      .o_id  (pick_id),
      .o_any (pick_any)
   );

   always_comb begin
      head_byte = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (gnt_q == SW'(k)) head_byte = i_src_data[8*k +: 8];
      end
   end

   assign head_valid = i_src_valid[gnt_q];

   // Outputs are a pure decode of state, grant and the live source inputs.
   always_comb begin
      o_valid   = 1'b0;
      o_data    = '0;
      o_src_deq = '0;
      case (state_q)
`ifdef FORMIC_TRACE_ARB_HDR_EN
         ST_HDR: begin
            o_valid = 1'b1;
            o_data  = hdr_byte(drop_flag_q[gnt_q], 8'(gnt_q));
         end
`endif
         ST_DATA: begin
            o_valid          = head_valid;
            o_data           = head_byte;
            o_src_deq[gnt_q] = head_valid & i_ready;
         end
         default: ;
      endcase
   end

   assign xfer = o_valid & i_ready;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
`ifdef FORMIC_TRACE_ARB_HDR_EN
      drop_clr   = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_d = pick_id;
`ifdef FORMIC_TRACE_ARB_HDR_EN
               state_d = ST_HDR;
`else
               state_d = ST_DATA;
`endif
            end
         end
`ifdef FORMIC_TRACE_ARB_HDR_EN
         ST_HDR: begin
            if (xfer) begin
               state_d         = ST_DATA;
               drop_clr[gnt_q] = 1'b1;
            end
         end
`endif
         ST_DATA: begin
            // A stalled source holds the grant; only a full record releases it.
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 3'd1;
               if (byte_cnt_q == REC_LAST) begin
                  state_d    = ST_IDLE;
                  rr_ptr_d   = gnt_q + SW'(1);
                  byte_cnt_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef FORMIC_TRACE_ARB_HDR_EN
   // A drop arriving in the header-transfer cycle survives into the next header.
   assign drop_flag_d = (drop_flag_q & ~drop_clr) | i_src_drop;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         rr_ptr_q    <= '0;
         byte_cnt_q  <= '0;
`ifdef FORMIC_TRACE_ARB_HDR_EN
         drop_flag_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rr_ptr_q    <= rr_ptr_d;
         byte_cnt_q  <= byte_cnt_d;
`ifdef FORMIC_TRACE_ARB_HDR_EN
         drop_flag_q <= drop_flag_d;
`endif
      end
   end

   assign o_busy = (state_q != ST_IDLE);
   assign o_gnt  = gnt_q;

endmodule
